// File: rtl/game_pkg.sv
`default_nettype none
// ============================================================================
// Module      : game_pkg
// Description : Shared definitions for the game sequencer and the renderer:
//               game-state encodings, step-divider limits and small helpers.
// Revision    : 1.0 - initial release
// ============================================================================
package game_pkg;

    // Game state encoding; the renderer decodes the same values.
    typedef logic [1:0] game_state_t;

    localparam logic [1:0] ST_IDLE  = 2'b00;
    localparam logic [1:0] ST_RUN   = 2'b01;
    localparam logic [1:0] ST_PAUSE = 2'b10;
    localparam logic [1:0] ST_OVER  = 2'b11;

    // Frames-per-step limits for the divider (a step fires when div >= limit).
    localparam logic [1:0] DIV_SLOW = 2'd3;
    localparam logic [1:0] DIV_MED  = 2'd1;
    localparam logic [1:0] DIV_FAST = 2'd0;

    localparam logic [7:0] SCORE_MAX = 8'd255;

    // Map the speed switches to a divider limit; any 1x setting is fastest.
    function automatic logic [1:0] speed_limit(input logic [1:0] sel);
        logic [1:0] lim;
        case (sel)
            2'b00:   lim = DIV_SLOW;
            2'b01:   lim = DIV_MED;
            default: lim = DIV_FAST;
        endcase
        return lim;
    endfunction

    // Score increment that sticks at the top of the 8-bit range.
    function automatic logic [7:0] score_inc(input logic [7:0] s);
        logic [7:0] r;
        if (s == SCORE_MAX) begin
            r = s;
        end else begin
            r = s + 8'd1;
        end
        return r;
    endfunction

endpackage : game_pkg
`default_nettype wire

// File: rtl/btn_debounce.sv
`default_nettype none
// ============================================================================
// Module      : btn_debounce
// Description : Two-flop synchroniser, stability counter and rising-edge
//               detector for one raw push button. Emits a one-cycle press
//               pulse for each accepted 0->1 change of the stable level.
// Revision    : 1.0 - initial release
// ============================================================================
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int CNT_W           = 18
) (
    input  logic clk_25,
    input  logic rst_n,
    input  logic btn,
    output logic press
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q,      sync1_d;
    logic             sync2_q,      sync2_d;
    logic             stable_q,     stable_d;
    logic             stable_dly_q, stable_dly_d;
    logic             press_q,      press_d;
    logic [CNT_W-1:0] cnt_q,        cnt_d;

    // Next-state logic: synchronise, count how long the new level persists,
    // accept it once it has been seen for DEBOUNCE_CYCLES cycles, then flag
    // the rising edge of the accepted level one cycle later.
    always_comb begin
        sync1_d      = btn;
        sync2_d      = sync1_q;
        stable_d     = stable_q;
        cnt_d        = cnt_q;
        if (sync2_q == stable_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            stable_d = sync2_q;
            cnt_d    = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
        stable_dly_d = stable_q;
        press_d      = stable_q & ~stable_dly_q;
    end

    // State registers, cleared asynchronously so no half-counted press survives reset.
    always_ff @(posedge clk_25 or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q      <= 1'b0;
            sync2_q      <= 1'b0;
            stable_q     <= 1'b0;
            stable_dly_q <= 1'b0;
            press_q      <= 1'b0;
            cnt_q        <= '0;
        end else begin
            sync1_q      <= sync1_d;
            sync2_q      <= sync2_d;
            stable_q     <= stable_d;
            stable_dly_q <= stable_dly_d;
            press_q      <= press_d;
            cnt_q        <= cnt_d;
        end
    end

    assign press = press_q;

endmodule : btn_debounce
`default_nettype wire

// File: rtl/game_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : game_ctrl
// Description : Frame-synchronous game sequencer. Debounces pause/jump,
//               tracks IDLE/RUN/PAUSE/OVER, and issues step/jump enables
//               aligned with the registered vsync falling edge. Keeps score.
// Revision    : 1.0 - initial release
// ============================================================================
module game_ctrl
    import game_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int CNT_W           = 18
) (
    input  logic       clk_25,
    input  logic       rst_n,
    input  logic       pause_btn,
    input  logic       jump_btn,
    input  logic [1:0] speed_sel,
    input  logic       vs,
    input  logic       collision,
    output logic [1:0] state,
    output logic       frame_start,
    output logic       step,
    output logic       jump,
    output logic [7:0] score
);

    logic pause_p;
    logic jump_p;

    btn_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W)
    ) u_pause_db (
        .clk_25 (clk_25),
        .rst_n  (rst_n),
        .btn    (pause_btn),
        .press  (pause_p)
    );

    btn_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W)
    ) u_jump_db (
        .clk_25 (clk_25),
        .rst_n  (rst_n),
        .btn    (jump_btn),
        .press  (jump_p)
    );

    // Synchronisers for speed switches and vsync, plus the vsync history bit.
    logic [1:0]  speed_s1_q, speed_s1_d;
    logic [1:0]  speed_s2_q, speed_s2_d;
    logic        vs_s1_q,    vs_s1_d;
    logic        vs_s2_q,    vs_s2_d;
    logic        vs_prev_q,  vs_prev_d;

    // Sequencer registers.
    game_state_t state_q,    state_d;
    logic        fs_q,       fs_d;
    logic        step_q,     step_d;
    logic        jump_q,     jump_d;
    logic [7:0]  score_q,    score_d;
    logic [1:0]  div_q,      div_d;
    logic        pend_q,     pend_d;
    logic [1:0]  limit;

    // Synchroniser shift: two flops per asynchronous input, one more for vs edge detection.
    always_comb begin
        speed_s1_d = speed_sel;
        speed_s2_d = speed_s1_q;
        vs_s1_d    = vs;
        vs_s2_d    = vs_s1_q;
        vs_prev_d  = vs_s2_q;
    end

    // Sequencer: every decision is taken from current (pre-update) state, and
    // frame-related outputs are registered on the same edge as frame_start.
    always_comb begin
        limit   = speed_limit(speed_s2_q);
        fs_d    = vs_prev_q & ~vs_s2_q;
        state_d = state_q;
        div_d   = div_q;
        pend_d  = pend_q;
        score_d = score_q;
        step_d  = 1'b0;
        jump_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // The starting press is consumed here and never latched as a jump.
                if (jump_p) begin
                    state_d = ST_RUN;
                    div_d   = '0;
                    pend_d  = 1'b0;
                    score_d = '0;
                end
            end
            ST_RUN: begin
                if (fs_d && collision) begin
                    // Collision wins over any coincident pause and yields no step.
                    state_d = ST_OVER;
                end else begin
                    if (fs_d) begin
                        // >= lets a lowered limit take effect on the very next frame.
                        if (div_q >= limit) begin
                            step_d = 1'b1;
                            div_d  = '0;
                        end else begin
                            div_d  = div_q + 2'd1;
                        end
                    end
                    if (jump_p) begin
                        pend_d = 1'b1;
                    end
                    if (step_d) begin
                        jump_d  = pend_q | jump_p;
                        pend_d  = 1'b0;
                        score_d = score_inc(score_q);
                    end
                    if (pause_p) begin
                        state_d = ST_PAUSE;
                    end
                end
            end
            ST_PAUSE: begin
                // Jump presses while paused are dropped; divider and latch are kept.
                if (pause_p) begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                if (jump_p) begin
                    state_d = ST_IDLE;
                end
            end
        endcase
    end

    // Register update with asynchronous clear of every flop.
    always_ff @(posedge clk_25 or negedge rst_n) begin
        if (!rst_n) begin
            speed_s1_q <= 2'b00;
            speed_s2_q <= 2'b00;
            vs_s1_q    <= 1'b0;
            vs_s2_q    <= 1'b0;
            vs_prev_q  <= 1'b0;
            state_q    <= ST_IDLE;
            fs_q       <= 1'b0;
            step_q     <= 1'b0;
            jump_q     <= 1'b0;
            score_q    <= '0;
            div_q      <= '0;
            pend_q     <= 1'b0;
        end else begin
            speed_s1_q <= speed_s1_d;
            speed_s2_q <= speed_s2_d;
            vs_s1_q    <= vs_s1_d;
            vs_s2_q    <= vs_s2_d;
            vs_prev_q  <= vs_prev_d;
            state_q    <= state_d;
            fs_q       <= fs_d;
            step_q     <= step_d;
            jump_q     <= jump_d;
            score_q    <= score_d;
            div_q      <= div_d;
            pend_q     <= pend_d;
        end
    end

    assign state       = state_q;
    assign frame_start = fs_q;
    assign step        = step_q;
    assign jump        = jump_q;
    assign score       = score_q;

endmodule : game_ctrl
`default_nettype wire

// File: tb/tb_game_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_game_ctrl
// Description : Directed self-checking bench for game_ctrl with
//               DEBOUNCE_CYCLES=4 and a 100-cycle vsync period.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_game_ctrl;

    logic       clk_25 = 1'b0;
    logic       rst_n;
    logic       pause_btn;
    logic       jump_btn;
    logic [1:0] speed_sel;
    logic       vs;
    logic       collision;
    logic [1:0] state;
    logic       frame_start;
    logic       step;
    logic       jump;
    logic [7:0] score;

    int checks = 0;
    int passed = 0;
    int vcnt   = 50;

    game_ctrl #(
        .DEBOUNCE_CYCLES (4),
        .CNT_W           (3)
    ) dut (
        .clk_25      (clk_25),
        .rst_n       (rst_n),
        .pause_btn   (pause_btn),
        .jump_btn    (jump_btn),
        .speed_sel   (speed_sel),
        .vs          (vs),
        .collision   (collision),
        .state       (state),
        .frame_start (frame_start),
        .step        (step),
        .jump        (jump),
        .score       (score)
    );

    always #20 clk_25 = ~clk_25;

    // One clock: inputs change and outputs are sampled 1 ns after the edge.
    // vs is low for vcnt 0..9, so frame_start is visible when vcnt==3.
    task automatic tick();
        @(posedge clk_25);
        #1;
        vcnt = (vcnt == 99) ? 0 : vcnt + 1;
        vs   = (vcnt < 10) ? 1'b0 : 1'b1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Advance to the next frame_start cycle (at most 100 ticks).
    task automatic wait_fs();
        tick();
        while (vcnt != 3) tick();
    endtask

    task automatic press_pause();
        pause_btn = 1'b1;
        ticks(10);
        pause_btn = 1'b0;
        ticks(8);
    endtask

    task automatic press_jump();
        jump_btn = 1'b1;
        ticks(10);
        jump_btn = 1'b0;
        ticks(8);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        ticks(3);
        checks++; if (state !== 2'b00) $display("FAIL reset_state got %b exp 00", state); else passed++;
        checks++; if (frame_start !== 1'b0) $display("FAIL reset_fs got %b exp 0", frame_start); else passed++;
        checks++; if (step !== 1'b0) $display("FAIL reset_step got %b exp 0", step); else passed++;
        checks++; if (jump !== 1'b0) $display("FAIL reset_jump got %b exp 0", jump); else passed++;
        checks++; if (score !== 8'd0) $display("FAIL reset_score got %0d exp 0", score); else passed++;
        rst_n = 1'b1;
        ticks(3);
    endtask

    task automatic test_start();
        int npress = 0;
        int at     = -1;
        jump_btn = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            tick();
            if (dut.u_jump_db.press === 1'b1) begin
                npress++;
                at = i;
            end
            if (i == 7) begin
                checks++; if (state !== 2'b00) $display("FAIL start_pre_state got %b exp 00", state); else passed++;
            end
            if (i == 8) begin
                checks++; if (state !== 2'b01) $display("FAIL start_state got %b exp 01", state); else passed++;
            end
        end
        jump_btn = 1'b0;
        ticks(8);
        checks++; if (npress != 1) $display("FAIL start_npress got %0d exp 1", npress); else passed++;
        checks++; if (at != 7) $display("FAIL start_press_cycle got %0d exp 7", at); else passed++;
        checks++; if (score !== 8'd0) $display("FAIL start_score got %0d exp 0", score); else passed++;
    endtask

    task automatic test_speed();
        for (int f = 1; f <= 13; f++) begin
            wait_fs();
            checks++; if (frame_start !== 1'b1) $display("FAIL speed_fs frame %0d got %b exp 1", f, frame_start); else passed++;
            checks++; if (step !== ((f % 4) == 0)) $display("FAIL speed_step frame %0d got %b exp %b", f, step, (f % 4) == 0); else passed++;
            checks++; if (jump !== 1'b0) $display("FAIL speed_jump frame %0d got %b exp 0", f, jump); else passed++;
            checks++; if (score !== 8'(f / 4)) $display("FAIL speed_score frame %0d got %0d exp %0d", f, score, f / 4); else passed++;
        end
        speed_sel = 2'b10;
        for (int f = 0; f < 2; f++) begin
            wait_fs();
            checks++; if (step !== 1'b1) $display("FAIL fast_step got %b exp 1", step); else passed++;
            checks++; if (score !== 8'(4 + f)) $display("FAIL fast_score got %0d exp %0d", score, 4 + f); else passed++;
        end
    endtask

    task automatic test_bounce();
        int entries = 0;
        logic [1:0] prev;
        prev = state;
        for (int i = 0; i < 50; i++) begin
            if (i < 20) pause_btn = (((i / 2) % 2) == 0);
            else if (i < 35) pause_btn = 1'b1;
            else pause_btn = 1'b0;
            tick();
            if (prev == 2'b01 && state == 2'b10) entries++;
            prev = state;
        end
        checks++; if (entries != 1) $display("FAIL bounce_entries got %0d exp 1", entries); else passed++;
        checks++; if (state !== 2'b10) $display("FAIL bounce_state got %b exp 10", state); else passed++;
        for (int f = 0; f < 3; f++) begin
            wait_fs();
            checks++; if (frame_start !== 1'b1) $display("FAIL pause_fs got %b exp 1", frame_start); else passed++;
            checks++; if (step !== 1'b0) $display("FAIL pause_step got %b exp 0", step); else passed++;
            checks++; if (score !== 8'd5) $display("FAIL pause_score got %0d exp 5", score); else passed++;
        end
    endtask

    task automatic test_jump_latch();
        press_jump();
        press_pause();
        checks++; if (state !== 2'b01) $display("FAIL resume_state got %b exp 01", state); else passed++;
        wait_fs();
        checks++; if (step !== 1'b1) $display("FAIL resume_step got %b exp 1", step); else passed++;
        checks++; if (jump !== 1'b0) $display("FAIL paused_jump_dropped got %b exp 0", jump); else passed++;
        checks++; if (score !== 8'd6) $display("FAIL resume_score got %0d exp 6", score); else passed++;
        press_jump();
        checks++; if (jump !== 1'b0) $display("FAIL latch_early_jump got %b exp 0", jump); else passed++;
        wait_fs();
        checks++; if (step !== 1'b1) $display("FAIL latch_step got %b exp 1", step); else passed++;
        checks++; if (jump !== 1'b1) $display("FAIL latch_jump got %b exp 1", jump); else passed++;
        checks++; if (score !== 8'd7) $display("FAIL latch_score got %0d exp 7", score); else passed++;
        wait_fs();
        checks++; if (step !== 1'b1) $display("FAIL latch_next_step got %b exp 1", step); else passed++;
        checks++; if (jump !== 1'b0) $display("FAIL latch_cleared got %b exp 0", jump); else passed++;
    endtask

    task automatic test_collision();
        collision = 1'b1;
        while (vcnt != 95) tick();
        pause_btn = 1'b1;
        while (vcnt != 2) tick();
        checks++; if (dut.u_pause_db.press !== 1'b1) $display("FAIL coll_pause_align got %b exp 1", dut.u_pause_db.press); else passed++;
        tick();
        checks++; if (frame_start !== 1'b1) $display("FAIL coll_fs got %b exp 1", frame_start); else passed++;
        checks++; if (state !== 2'b11) $display("FAIL coll_state got %b exp 11", state); else passed++;
        checks++; if (step !== 1'b0) $display("FAIL coll_step got %b exp 0", step); else passed++;
        checks++; if (score !== 8'd8) $display("FAIL coll_score got %0d exp 8", score); else passed++;
        ticks(6);
        pause_btn = 1'b0;
        wait_fs();
        checks++; if (step !== 1'b0) $display("FAIL over_step got %b exp 0", step); else passed++;
        checks++; if (score !== 8'd8) $display("FAIL over_score got %0d exp 8", score); else passed++;
        checks++; if (state !== 2'b11) $display("FAIL over_state got %b exp 11", state); else passed++;
        collision = 1'b0;
        press_jump();
        checks++; if (state !== 2'b00) $display("FAIL over_to_idle got %b exp 00", state); else passed++;
        press_jump();
        checks++; if (state !== 2'b01) $display("FAIL restart_state got %b exp 01", state); else passed++;
        checks++; if (score !== 8'd0) $display("FAIL restart_score got %0d exp 0", score); else passed++;
    endtask

    task automatic test_saturation();
        for (int f = 1; f <= 300; f++) begin
            wait_fs();
            if (f == 255) begin
                checks++; if (score !== 8'd255) $display("FAIL sat_score_255 got %0d exp 255", score); else passed++;
            end
        end
        checks++; if (step !== 1'b1) $display("FAIL sat_step got %b exp 1", step); else passed++;
        checks++; if (score !== 8'd255) $display("FAIL sat_score got %0d exp 255", score); else passed++;
        // Reset lands in the middle of a frame_start/step cycle.
        rst_n = 1'b0;
        #1;
        checks++; if (state !== 2'b00) $display("FAIL async_state got %b exp 00", state); else passed++;
        checks++; if (frame_start !== 1'b0) $display("FAIL async_fs got %b exp 0", frame_start); else passed++;
        checks++; if (step !== 1'b0) $display("FAIL async_step got %b exp 0", step); else passed++;
        checks++; if (jump !== 1'b0) $display("FAIL async_jump got %b exp 0", jump); else passed++;
        checks++; if (score !== 8'd0) $display("FAIL async_score got %0d exp 0", score); else passed++;
        ticks(2);
        rst_n = 1'b1;
        ticks(2);
    endtask

    initial begin
        rst_n     = 1'b0;
        pause_btn = 1'b0;
        jump_btn  = 1'b0;
        speed_sel = 2'b00;
        vs        = 1'b1;
        collision = 1'b0;
        test_reset();
        test_start();
        test_speed();
        test_bounce();
        test_jump_latch();
        test_collision();
        test_saturation();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule : tb_game_ctrl
`default_nettype wire
